// File: rtl/pc_redirect_arbiter_pkg.sv
// rtl/pc_redirect_arbiter_pkg.sv - shared types and constants for the PC redirect arbiter
package pcu_pkg;

   // Default redirect address width.
   localparam int ADDR_W_DEFAULT = 32;

   // Encoding doubles as priority rank: a larger value wins.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_BR   = 2'd1,
      SRC_MRET = 2'd2,
      SRC_TRAP = 2'd3
   } redirect_src_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      FLUSH = 2'd2
   } arb_state_e;

endpackage

// File: rtl/pc_redirect_arbiter_if.sv
// rtl/pc_redirect_arbiter_if.sv - redirect handshake between the arbiter and the PC unit
interface pc_redirect_arbiter_if
   import pcu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
);
   logic              pcu_ready_i;
   logic              jump_flag_o;
   logic [ADDR_W-1:0] jump_addr_o;
   logic [1:0]        redirect_src_o;
   logic              flush_o;
   logic              busy_o;

   // Arbiter side: drives the redirect, observes PC unit readiness.
   modport master (
      input  pcu_ready_i,
      output jump_flag_o, jump_addr_o, redirect_src_o, flush_o, busy_o
   );

   // PC unit side.
   modport slave (
      output pcu_ready_i,
      input  jump_flag_o, jump_addr_o, redirect_src_o, flush_o, busy_o
   );
endinterface

// File: rtl/pc_redirect_arbiter_prio_enc.sv
// rtl/pc_redirect_arbiter_prio_enc.sv - fixed-priority select of trap > mret > branch
module redirect_prio_enc
   import pcu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              br_valid,
   input  logic [ADDR_W-1:0] br_addr,
   input  logic              mret_valid,
   input  logic [ADDR_W-1:0] mret_addr,
   input  logic              trap_valid,
   input  logic [ADDR_W-1:0] trap_addr,
   output logic              sel_valid,
   output redirect_src_e     sel_src,
   output logic [ADDR_W-1:0] sel_addr
);

   // Highest-ranked active request wins; the rest are simply not selected.
   always_comb begin
      sel_valid = 1'b0;
      sel_src   = SRC_NONE;
      sel_addr  = '0;
      if (trap_valid) begin
         sel_valid = 1'b1;
         sel_src   = SRC_TRAP;
         sel_addr  = trap_addr;
      end else if (mret_valid) begin
         sel_valid = 1'b1;
         sel_src   = SRC_MRET;
         sel_addr  = mret_addr;
      end else if (br_valid) begin
         sel_valid = 1'b1;
         sel_src   = SRC_BR;
         sel_addr  = br_addr;
      end
   end

endmodule

// File: rtl/pc_redirect_arbiter.sv
// rtl/pc_redirect_arbiter.sv - redirect sequencer into the PC unit; REDIRECT_CNT_EN adds an accept counter
module pc_redirect_arbiter
   import pcu_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEFAULT,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   pc_redirect_arbiter_if.master pcu,
   input  logic                 br_valid_i,
   input  logic [ADDR_W-1:0]    br_addr_i,
   input  logic                 trap_valid_i,
   input  logic [ADDR_W-1:0]    trap_addr_i,
   input  logic                 mret_valid_i,
   input  logic [ADDR_W-1:0]    mret_addr_i
`ifdef REDIRECT_CNT_EN
   ,
   output logic [31:0]          redirect_cnt_o
`endif
);

   // Instruction fetch is word aligned, so the two low address bits are always cleared.
   localparam logic [ADDR_W-1:0] ADDR_MASK  = ~(ADDR_W'(3));
   localparam logic [3:0]        FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   arb_state_e        state_q;
   logic              jump_flag_q;
   logic [ADDR_W-1:0] jump_addr_q;
   redirect_src_e     src_q;
   logic              flush_q;
   logic [3:0]        flush_cnt_q;
   logic              pend_trap_q;
   logic [ADDR_W-1:0] pend_addr_q;

   logic              sel_valid;
   redirect_src_e     sel_src;
   logic [ADDR_W-1:0] sel_addr;

   redirect_prio_enc #(.ADDR_W(ADDR_W)) u_prio (
      .br_valid   (br_valid_i),
      .br_addr    (br_addr_i),
      .mret_valid (mret_valid_i),
      .mret_addr  (mret_addr_i),
      .trap_valid (trap_valid_i),
      .trap_addr  (trap_addr_i),
      .sel_valid  (sel_valid),
      .sel_src    (sel_src),
      .sel_addr   (sel_addr)
   );

   // Redirect FSM: latch a winner, hold it until accepted, then flush; a trap seen late is parked.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         jump_flag_q <= 1'b0;
         jump_addr_q <= '0;
         src_q       <= SRC_NONE;
         flush_q     <= 1'b0;
         flush_cnt_q <= '0;
         pend_trap_q <= 1'b0;
         pend_addr_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sel_valid) begin
                  state_q     <= ISSUE;
                  jump_flag_q <= 1'b1;
                  jump_addr_q <= sel_addr & ADDR_MASK;
                  src_q       <= sel_src;
               end
            end
            ISSUE: begin
               if (pcu.pcu_ready_i) begin
                  state_q     <= FLUSH;
                  jump_flag_q <= 1'b0;
                  flush_q     <= 1'b1;
                  flush_cnt_q <= FLUSH_LOAD;
                  // The accepted redirect is already gone; a trap that would have replaced it waits.
                  if (trap_valid_i && src_q != SRC_TRAP) begin
                     pend_trap_q <= 1'b1;
                     pend_addr_q <= trap_addr_i;
                  end
               end else if (sel_valid && sel_src > src_q) begin
                  jump_addr_q <= sel_addr & ADDR_MASK;
                  src_q       <= sel_src;
               end
            end
            FLUSH: begin
               if (flush_cnt_q == 4'd0) begin
                  flush_q <= 1'b0;
                  // A trap arriving in the final flush cycle is honoured the same as a parked one.
                  if (pend_trap_q || trap_valid_i) begin
                     state_q     <= ISSUE;
                     jump_flag_q <= 1'b1;
                     jump_addr_q <= (pend_trap_q ? pend_addr_q : trap_addr_i) & ADDR_MASK;
                     src_q       <= SRC_TRAP;
                     pend_trap_q <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  flush_cnt_q <= flush_cnt_q - 4'd1;
                  if (trap_valid_i && !pend_trap_q) begin
                     pend_trap_q <= 1'b1;
                     pend_addr_q <= trap_addr_i;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef REDIRECT_CNT_EN
   logic [31:0] redirect_cnt_q;

   // Count each accepted redirect, saturating rather than wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         redirect_cnt_q <= '0;
      end else if (state_q == ISSUE && pcu.pcu_ready_i && redirect_cnt_q != 32'hFFFF_FFFF) begin
         redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
   end

   assign redirect_cnt_o = redirect_cnt_q;
`endif

   assign pcu.jump_flag_o    = jump_flag_q;
   assign pcu.jump_addr_o    = jump_addr_q;
   assign pcu.redirect_src_o = src_q;
   assign pcu.flush_o        = flush_q;
   assign pcu.busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_pc_redirect_arbiter.sv
// tb/tb_pc_redirect_arbiter.sv - self-checking bench for pc_redirect_arbiter
module tb_pc_redirect_arbiter;

   localparam int FLUSH_CYCLES = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        br_valid, mret_valid, trap_valid;
   logic [31:0] br_addr, mret_addr, trap_addr;
`ifdef REDIRECT_CNT_EN
   logic [31:0] redirect_cnt;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: what the PC unit should be seeing right now.
   bit          m_issuing;
   int          m_flush_left;
   int          m_src;
   logic [31:0] m_addr;
   bit          m_pend;
   logic [31:0] m_pend_addr;
   longint      m_cnt;

   pc_redirect_arbiter_if #(.ADDR_W(32)) pcu_bus ();

   pc_redirect_arbiter #(.ADDR_W(32), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
      .clk          (clk),
      .reset        (reset),
      .pcu          (pcu_bus),
      .br_valid_i   (br_valid),
      .br_addr_i    (br_addr),
      .trap_valid_i (trap_valid),
      .trap_addr_i  (trap_addr),
      .mret_valid_i (mret_valid),
      .mret_addr_i  (mret_addr)
`ifdef REDIRECT_CNT_EN
      ,
      .redirect_cnt_o (redirect_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic model_update(input bit b, input logic [31:0] ba, input bit m, input logic [31:0] ma,
                               input bit t, input logic [31:0] ta, input bit rdy, input bit rst);
      int          best;
      logic [31:0] best_addr;
      best = 0;
      best_addr = 0;
      if (t) begin best = 3; best_addr = ta; end
      else if (m) begin best = 2; best_addr = ma; end
      else if (b) begin best = 1; best_addr = ba; end
      if (rst) begin
         m_issuing = 0; m_flush_left = 0; m_src = 0; m_addr = 0; m_pend = 0; m_pend_addr = 0; m_cnt = 0;
      end else if (m_issuing) begin
         if (rdy) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            m_issuing = 0;
            m_flush_left = FLUSH_CYCLES;
            if (t && m_src != 3) begin m_pend = 1; m_pend_addr = ta; end
         end else if (best > m_src) begin
            m_src = best; m_addr = best_addr;
         end
      end else if (m_flush_left > 0) begin
         if (t && !m_pend) begin m_pend = 1; m_pend_addr = ta; end
         m_flush_left--;
         if (m_flush_left == 0 && m_pend) begin
            m_issuing = 1; m_src = 3; m_addr = m_pend_addr; m_pend = 0;
         end
      end else if (best > 0) begin
         m_issuing = 1; m_src = best; m_addr = best_addr;
      end
   endtask

   task automatic step(input bit b, input logic [31:0] ba, input bit m, input logic [31:0] ma,
                       input bit t, input logic [31:0] ta, input bit rdy, input bit rst);
      br_valid = b; br_addr = ba; mret_valid = m; mret_addr = ma;
      trap_valid = t; trap_addr = ta; pcu_bus.pcu_ready_i = rdy; reset = rst;
      @(posedge clk);
      model_update(b, ba, m, ma, t, ta, rdy, rst);
      #1;
      br_valid = 0; mret_valid = 0; trap_valid = 0; reset = 0;
   endtask

   task automatic test_reset();
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      total++; if (pcu_bus.jump_flag_o !== 1'b0) begin bad++; $display("FAIL rst_flag got=%0d want=0", pcu_bus.jump_flag_o); end
      total++; if (pcu_bus.jump_addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", pcu_bus.jump_addr_o); end
      total++; if (pcu_bus.redirect_src_o !== 2'd0) begin bad++; $display("FAIL rst_src got=%0d want=0", pcu_bus.redirect_src_o); end
      total++; if (pcu_bus.flush_o !== 1'b0) begin bad++; $display("FAIL rst_flush got=%0d want=0", pcu_bus.flush_o); end
      total++; if (pcu_bus.busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d want=0", pcu_bus.busy_o); end
   endtask

   task automatic test_branch();
      step(1, 32'h100, 0, 0, 0, 0, 1, 0);
      total++; if (pcu_bus.jump_flag_o !== 1'b1) begin bad++; $display("FAIL br_flag got=%0d want=1", pcu_bus.jump_flag_o); end
      total++; if (pcu_bus.jump_addr_o !== 32'h100) begin bad++; $display("FAIL br_addr got=%h want=100", pcu_bus.jump_addr_o); end
      total++; if (pcu_bus.redirect_src_o !== 2'd1) begin bad++; $display("FAIL br_src got=%0d want=1", pcu_bus.redirect_src_o); end
      step(0, 0, 0, 0, 0, 0, 1, 0);
      total++; if ({pcu_bus.jump_flag_o, pcu_bus.flush_o} !== 2'b01) begin bad++; $display("FAIL br_flush1 got=%b want=01", {pcu_bus.jump_flag_o, pcu_bus.flush_o}); end
      step(0, 0, 0, 0, 0, 0, 1, 0);
      total++; if (pcu_bus.flush_o !== 1'b1) begin bad++; $display("FAIL br_flush2 got=%0d want=1", pcu_bus.flush_o); end
      step(0, 0, 0, 0, 0, 0, 1, 0);
      total++; if ({pcu_bus.flush_o, pcu_bus.busy_o, pcu_bus.jump_flag_o} !== 3'b000) begin bad++; $display("FAIL br_idle got=%b want=000", {pcu_bus.flush_o, pcu_bus.busy_o, pcu_bus.jump_flag_o}); end
      total++; if (pcu_bus.redirect_src_o !== 2'd1) begin bad++; $display("FAIL br_src_hold got=%0d want=1", pcu_bus.redirect_src_o); end
   endtask

   task automatic test_simultaneous();
      step(1, 32'h200, 0, 0, 1, 32'h80, 0, 0);
      total++; if (pcu_bus.jump_addr_o !== 32'h80) begin bad++; $display("FAIL sim_addr got=%h want=80", pcu_bus.jump_addr_o); end
      total++; if (pcu_bus.redirect_src_o !== 2'd3) begin bad++; $display("FAIL sim_src got=%0d want=3", pcu_bus.redirect_src_o); end
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      total++; if ({pcu_bus.busy_o, pcu_bus.jump_flag_o} !== 2'b00) begin bad++; $display("FAIL sim_no_branch got=%b want=00", {pcu_bus.busy_o, pcu_bus.jump_flag_o}); end
   endtask

   task automatic test_replace();
      step(1, 32'h300, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (pcu_bus.jump_addr_o !== 32'h300) begin bad++; $display("FAIL rep_hold got=%h want=300", pcu_bus.jump_addr_o); end
      step(0, 0, 1, 32'h404, 0, 0, 0, 0);
      total++; if (pcu_bus.jump_addr_o !== 32'h404) begin bad++; $display("FAIL rep_addr got=%h want=404", pcu_bus.jump_addr_o); end
      total++; if (pcu_bus.redirect_src_o !== 2'd2) begin bad++; $display("FAIL rep_src got=%0d want=2", pcu_bus.redirect_src_o); end
      step(1, 32'h500, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      total++; if ({pcu_bus.jump_flag_o, pcu_bus.jump_addr_o} !== {1'b1, 32'h404}) begin bad++; $display("FAIL rep_drop got=%h want=404", pcu_bus.jump_addr_o); end
      step(0, 0, 0, 0, 0, 0, 1, 0);
      total++; if ({pcu_bus.jump_flag_o, pcu_bus.flush_o} !== 2'b01) begin bad++; $display("FAIL rep_accept got=%b want=01", {pcu_bus.jump_flag_o, pcu_bus.flush_o}); end
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_flush_trap();
      step(1, 32'h500, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 32'h600, 0, 0, 1, 32'h80, 1, 0);
      total++; if ({pcu_bus.jump_flag_o, pcu_bus.flush_o} !== 2'b01) begin bad++; $display("FAIL ft_flush got=%b want=01", {pcu_bus.jump_flag_o, pcu_bus.flush_o}); end
      step(0, 0, 0, 0, 0, 0, 0, 0);
      total++; if ({pcu_bus.jump_flag_o, pcu_bus.flush_o, pcu_bus.busy_o} !== 3'b101) begin bad++; $display("FAIL ft_issue got=%b want=101", {pcu_bus.jump_flag_o, pcu_bus.flush_o, pcu_bus.busy_o}); end
      total++; if (pcu_bus.jump_addr_o !== 32'h80) begin bad++; $display("FAIL ft_addr got=%h want=80", pcu_bus.jump_addr_o); end
      total++; if (pcu_bus.redirect_src_o !== 2'd3) begin bad++; $display("FAIL ft_src got=%0d want=3", pcu_bus.redirect_src_o); end
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (pcu_bus.busy_o !== 1'b0) begin bad++; $display("FAIL ft_idle got=%0d want=0", pcu_bus.busy_o); end
   endtask

   task automatic test_align_reset();
      step(1, 32'h103, 0, 0, 0, 0, 0, 0);
      total++; if (pcu_bus.jump_addr_o !== 32'h100) begin bad++; $display("FAIL al_addr got=%h want=100", pcu_bus.jump_addr_o); end
      step(0, 0, 0, 0, 0, 0, 0, 1);
      total++; if ({pcu_bus.jump_flag_o, pcu_bus.flush_o, pcu_bus.busy_o, pcu_bus.redirect_src_o} !== 5'b0) begin bad++; $display("FAIL al_rst got=%b want=00000", {pcu_bus.jump_flag_o, pcu_bus.flush_o, pcu_bus.busy_o, pcu_bus.redirect_src_o}); end
      total++; if (pcu_bus.jump_addr_o !== 32'h0) begin bad++; $display("FAIL al_rst_addr got=%h want=0", pcu_bus.jump_addr_o); end
   endtask

`ifdef REDIRECT_CNT_EN
   task automatic test_count();
      step(1, 32'h10, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 32'h14, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 32'h20, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 32'h30, 0, 0, 0, 0);
      step(1, 32'h34, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 32'h40, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (redirect_cnt !== 32'd3) begin bad++; $display("FAIL cnt got=%0d want=3", redirect_cnt); end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 5) == 0), $urandom, ($urandom_range(0, 7) == 0), $urandom,
              ($urandom_range(0, 9) == 0), $urandom, $urandom_range(0, 1) == 1, ($urandom_range(0, 99) == 0));
         total++; if (pcu_bus.jump_flag_o !== m_issuing) begin bad++; $display("FAIL rnd_flag i=%0d got=%0d want=%0d", i, pcu_bus.jump_flag_o, m_issuing); end
         total++; if (pcu_bus.flush_o !== (m_flush_left > 0)) begin bad++; $display("FAIL rnd_flush i=%0d got=%0d want=%0d", i, pcu_bus.flush_o, m_flush_left > 0); end
         total++; if (pcu_bus.jump_addr_o !== (m_addr & 32'hFFFF_FFFC)) begin bad++; $display("FAIL rnd_addr i=%0d got=%h want=%h", i, pcu_bus.jump_addr_o, m_addr & 32'hFFFF_FFFC); end
         total++; if (pcu_bus.redirect_src_o !== 2'(m_src)) begin bad++; $display("FAIL rnd_src i=%0d got=%0d want=%0d", i, pcu_bus.redirect_src_o, m_src); end
         total++; if (pcu_bus.busy_o !== (m_issuing || m_flush_left > 0)) begin bad++; $display("FAIL rnd_busy i=%0d got=%0d want=%0d", i, pcu_bus.busy_o, m_issuing || m_flush_left > 0); end
         total++; if ((pcu_bus.jump_flag_o && pcu_bus.flush_o) !== 1'b0) begin bad++; $display("FAIL rnd_excl i=%0d got=1 want=0", i); end
`ifdef REDIRECT_CNT_EN
         total++; if (redirect_cnt !== 32'(m_cnt)) begin bad++; $display("FAIL rnd_cnt i=%0d got=%0d want=%0d", i, redirect_cnt, m_cnt); end
`endif
      end
   endtask

   initial begin
      reset = 1'b1;
      br_valid = 0; mret_valid = 0; trap_valid = 0;
      br_addr = 0; mret_addr = 0; trap_addr = 0;
      pcu_bus.pcu_ready_i = 1'b0;
      test_reset();
      test_branch();
      test_simultaneous();
      test_replace();
      test_flush_trap();
      test_align_reset();
`ifdef REDIRECT_CNT_EN
      test_count();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
